// File: rtl/instr_mem_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them into instruction RAM.
// Keeps the core in reset until the whole image is written. Optional LOADER_CHECKSUM_EN adds a trailer-byte check.
module instr_mem_loader #(
  parameter int DATA_WIDTH      = 32,
  parameter int INSTR_MEM_DEPTH = 1024,
  parameter int CNT_WIDTH       = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  WE,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] WD,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;
`endif

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(INSTR_MEM_DEPTH);

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  word_idx, word_idx_n;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_q_n;
  logic [1:0]            byte_cnt, byte_cnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  ready_n, we_n, cpu_rst_n_n, busy_n, done_n, error_n;
  logic [DATA_WIDTH-1:0] a_n, wd_n;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            sum, sum_n;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      word_idx   <= '0;
      cnt_q      <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
      byte_ready <= 1'b0;
      WE         <= 1'b0;
      A          <= '0;
      WD         <= '0;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      state      <= state_n;
      word_idx   <= word_idx_n;
      cnt_q      <= cnt_q_n;
      byte_cnt   <= byte_cnt_n;
      shreg      <= shreg_n;
      byte_ready <= ready_n;
      WE         <= we_n;
      A          <= a_n;
      WD         <= wd_n;
      cpu_rst_n  <= cpu_rst_n_n;
      busy       <= busy_n;
      done       <= done_n;
      error      <= error_n;
`ifdef LOADER_CHECKSUM_EN
      sum        <= sum_n;
`endif
    end
  end

  // Outputs are decoded from the next state so that they are registered yet line up with the state.
  always_comb begin
    state_n    = state;
    word_idx_n = word_idx;
    cnt_q_n    = cnt_q;
    byte_cnt_n = byte_cnt;
    shreg_n    = shreg;
`ifdef LOADER_CHECKSUM_EN
    sum_n      = sum;
`endif

    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          if (word_count == '0 || word_count > DEPTH_C) begin
            state_n = ERR;
          end else begin
            state_n    = RECV;
            word_idx_n = '0;
            byte_cnt_n = '0;
            cnt_q_n    = word_count;
`ifdef LOADER_CHECKSUM_EN
            sum_n      = '0;
`endif
          end
        end
      end
      RECV: begin
        if (byte_valid && byte_ready) begin
          shreg_n    = {shreg[DATA_WIDTH-9:0], byte_in};
          byte_cnt_n = byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_n      = sum + byte_in;
`endif
          if (byte_cnt == 2'd3) state_n = WRITE;
        end
      end
      WRITE: begin
        word_idx_n = word_idx + 1'b1;
        byte_cnt_n = '0;
        if (word_idx_n == cnt_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_n = CHK;
`else
          state_n = DONE;
`endif
        end else begin
          state_n = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (byte_valid && byte_ready) begin
          state_n = (8'(sum + byte_in) == 8'd0) ? DONE : ERR;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

`ifdef LOADER_CHECKSUM_EN
    ready_n = (state_n == RECV) || (state_n == CHK);
    busy_n  = (state_n == RECV) || (state_n == WRITE) || (state_n == CHK);
`else
    ready_n = (state_n == RECV);
    busy_n  = (state_n == RECV) || (state_n == WRITE);
`endif
    we_n        = (state_n == WRITE);
    cpu_rst_n_n = (state_n == DONE);
    done_n      = (state_n == DONE);
    error_n     = (state_n == ERR);
    a_n         = A;
    wd_n        = WD;
    if (state_n == WRITE) begin
      a_n  = DATA_WIDTH'({word_idx_n, 2'b00});
      wd_n = shreg_n;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: RAM writes are checked against a scoreboard of expected {A, WD}.
// Defining LOADER_CHECKSUM_EN for both files also exercises the trailer-byte path.
module tb_instr_mem_loader;
  localparam int CW = 11;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] word_count = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready, WE, cpu_rst_n, busy, done, error;
  logic [31:0]   A, WD;

  int          checks = 0;
  int          passes = 0;
  logic [63:0] sb[$];
  logic [7:0]  img[$];
  logic [31:0] exp_addr;

  always #5 CLK = ~CLK;

  instr_mem_loader #(.DATA_WIDTH(32), .INSTR_MEM_DEPTH(1024), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .WE(WE), .A(A), .WD(WD), .cpu_rst_n(cpu_rst_n), .busy(busy),
    .done(done), .error(error)
  );

  function automatic logic [31:0] ctl();
    return {26'd0, byte_ready, WE, cpu_rst_n, busy, done, error};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes += 1;
    else $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Every write pulse must match the oldest outstanding expected word.
  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("we_unexpected", 32'(WE), 32'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        checkOutput("we_addr", A, e[63:32]);
        checkOutput("we_data", WD, e[31:0]);
        checkOutput("ready_in_write", 32'(byte_ready), 32'd0);
      end
    end
  end

  task automatic pulseStart(input logic [CW-1:0] wc);
    word_count = wc;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    exp_addr = 32'd0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gap);
    int waited;
    waited = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (byte_ready !== 1'b1) begin
      checkOutput("byte_timeout", 32'(byte_ready), 32'd1);
      byte_valid = 1'b0;
      return;
    end
    @(negedge CLK);
    byte_valid = 1'b0;
    if (gap) @(negedge CLK);
  endtask

  task automatic pushWord(input int i);
    sb.push_back({exp_addr, img[i], img[i+1], img[i+2], img[i+3]});
    exp_addr += 32'd4;
  endtask

  task automatic applyStimulus(input bit gap);
    logic [7:0] sum;
    sum = 8'd0;
    for (int i = 0; i < img.size(); i++) begin
      if (i % 4 == 0) pushWord(i);
      sum += img[i];
      sendByte(img[i], gap);
    end
`ifdef LOADER_CHECKSUM_EN
    sendByte(8'(8'd0 - sum), gap);
`endif
  endtask

  task automatic waitEnd();
    int n;
    n = 0;
    while (!(done === 1'b1 || error === 1'b1) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (!(done === 1'b1 || error === 1'b1)) checkOutput("end_timeout", 32'(done | error), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset, then idle with no start
    #2 RST = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("reset_ctl", ctl(), 32'd0);
    checkOutput("reset_a_wd", A | WD, 32'd0);
    RST = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      checkOutput("idle_ctl", ctl(), 32'd0);
      checkOutput("idle_a_wd", A | WD, 32'd0);
    end

    // Two-word load, valid every cycle
    img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h12, 8'h34};
    pulseStart(11'd2);
    checkOutput("start_ctl", ctl(), 32'h24);
    applyStimulus(1'b0);
    waitEnd();
    checkOutput("load2_done_ctl", ctl(), 32'h0A);
    checkOutput("load2_last_a", A, 32'h4);
    checkOutput("load2_last_wd", WD, 32'h3C011234);
    checkOutput("load2_sb_drained", 32'(sb.size()), 32'd0);

    // Same stream with byte_valid toggling
    pulseStart(11'd2);
    checkOutput("restart_ctl", ctl(), 32'h24);
    applyStimulus(1'b1);
    waitEnd();
    checkOutput("gap_done_ctl", ctl(), 32'h0A);
    checkOutput("gap_sb_drained", 32'(sb.size()), 32'd0);

    // Bad counts: zero, then one past the memory depth
    pulseStart(11'd0);
    waitEnd();
    checkOutput("cnt0_ctl", ctl(), 32'h01);
    repeat (5) @(negedge CLK);
    checkOutput("cnt0_held", ctl(), 32'h01);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("cnt_reset_ctl", ctl(), 32'd0);
    pulseStart(11'd1025);
    waitEnd();
    checkOutput("cnt1025_ctl", ctl(), 32'h01);
    repeat (5) @(negedge CLK);

    // Full-depth image: last word lands at 4*(DEPTH-1)
    img.delete();
    for (int i = 0; i < 4096; i++) img.push_back(8'($urandom));
    pulseStart(11'd1024);
    applyStimulus(1'b0);
    waitEnd();
    checkOutput("full_done_ctl", ctl(), 32'h0A);
    checkOutput("full_last_a", A, 32'hFFC);
    checkOutput("full_sb_drained", 32'(sb.size()), 32'd0);

    // Reset asserted after 6 bytes of a 2-word load
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    pulseStart(11'd2);
    pushWord(0);
    for (int i = 0; i < 6; i++) sendByte(img[i], 1'b0);
    #2 RST = 1'b0;
    #1;
    checkOutput("midload_rst_ctl", ctl(), 32'd0);
    checkOutput("midload_rst_a_wd", A | WD, 32'd0);
    checkOutput("midload_sb_drained", 32'(sb.size()), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    pulseStart(11'd1);
    applyStimulus(1'b0);
    waitEnd();
    checkOutput("reload_done_ctl", ctl(), 32'h0A);
    checkOutput("reload_a", A, 32'h0);
    checkOutput("reload_wd", WD, 32'hDEADBEEF);

`ifdef LOADER_CHECKSUM_EN
    // Trailer byte makes the 8-bit sum zero, then one that does not
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    pulseStart(11'd1);
    pushWord(0);
    for (int i = 0; i < 4; i++) sendByte(img[i], 1'b0);
    checkOutput("chk_busy", 32'(busy), 32'd1);
    sendByte(8'hF6, 1'b0);
    waitEnd();
    checkOutput("chk_good_ctl", ctl(), 32'h0A);
    pulseStart(11'd1);
    pushWord(0);
    for (int i = 0; i < 4; i++) sendByte(img[i], 1'b0);
    sendByte(8'hF5, 1'b0);
    waitEnd();
    checkOutput("chk_bad_ctl", ctl(), 32'h01);
    checkOutput("chk_sb_drained", 32'(sb.size()), 32'd0);
`endif

    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
